sys_array_pe: RTL and testbench

- Single processing element (PE) of a weight-stationary systolic array; the array instantiates a 2-D grid of these.
- Each cycle it computes a signed multiply-accumulate, out_data = prop_data + input_data * weight, and registers the result for the next PE down the column.
- The weight is either latched on a load strobe (LOAD variant) or taken directly from the input each cycle (SIMPLE variant).
- Its stored weight is forwarded on prop_param so neighbouring PEs can daisy-chain weight loading.

---
 rtl/sys_array_pkg.sv | 13 +
 rtl/sys_array_pe_if.sv | 30 +++
 rtl/sys_array_mac.sv | 25 ++
 rtl/sys_array_pe.sv | 59 +++++
 tb/tb_sys_array_pe.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic array and its processing elements.
//   cell_type_t      : PE weight-handling variant
//   DEF_DATA_WIDTH   : default operand width (accumulator is twice this)
package sys_array_pkg;

  typedef enum logic {
    CELL_LOAD   = 1'b0,  // weight latched on param_load
    CELL_SIMPLE = 1'b1   // weight follows param_data every cycle
  } cell_type_t;

  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/sys_array_pe_if.sv
// PE data bus.
//   param_load  : weight load strobe (CELL_LOAD only)
//   input_data  : activation operand
//   prop_data   : partial sum from upstream PE
//   param_data  : weight operand / load value
//   out_data    : registered partial sum to downstream PE
//   prop_param  : registered weight, forwarded to the neighbouring PE
// master = array side driving operands, slave = PE.
interface sys_array_pe_if
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                           param_load;
  logic signed [DATA_WIDTH-1:0]   input_data;
  logic signed [2*DATA_WIDTH-1:0] prop_data;
  logic signed [DATA_WIDTH-1:0]   param_data;
  logic signed [2*DATA_WIDTH-1:0] out_data;
  logic signed [DATA_WIDTH-1:0]   prop_param;

  modport master (
    output param_load, input_data, prop_data, param_data,
    input  out_data, prop_param
  );

  modport slave (
    input  param_load, input_data, prop_data, param_data,
    output out_data, prop_param
  );
endinterface

// File: rtl/sys_array_mac.sv
// Combinational signed multiply-add: sum = acc + a * b.
//   a, b : DATA_WIDTH signed operands
//   acc  : 2*DATA_WIDTH signed addend
//   sum  : 2*DATA_WIDTH signed result, wraps modulo 2^(2*DATA_WIDTH)
module sys_array_mac
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0]   a,
  input  logic signed [DATA_WIDTH-1:0]   b,
  input  logic signed [2*DATA_WIDTH-1:0] acc,
  output logic signed [2*DATA_WIDTH-1:0] sum
);
  localparam int AW = 2 * DATA_WIDTH;

  logic signed [AW-1:0] a_ext, b_ext, prod;

  // Explicit sign extension so the product is formed at full width;
  // W x W signed always fits in 2W bits (including -2^(W-1) squared).
  assign a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign b_ext = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;
  assign sum   = acc + prod;
endmodule

// File: rtl/sys_array_pe.sv
// Weight-stationary systolic array processing element.
//   clk      : rising-edge clock
//   reset_n  : synchronous reset, active HIGH (1 = reset)
//   bus      : sys_array_pe_if.slave (operands in, out_data/prop_param out)
// out_data <= prop_data + input_data * weight, one cycle latency.
// CELL_LOAD uses the registered weight (new weight visible the cycle
// after the load edge); CELL_SIMPLE uses param_data directly.
module sys_array_pe
  import sys_array_pkg::*;
#(
  parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
  parameter cell_type_t TYPE       = CELL_LOAD
) (
  input  logic           clk,
  input  logic           reset_n,
  sys_array_pe_if.slave  bus
);
  localparam int AW = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] w_q, w_next, mac_w;
  logic signed [AW-1:0]         out_q, mac_sum;

  generate
    if (TYPE == CELL_LOAD) begin : g_load
      always_comb begin
        w_next = w_q;
        if (bus.param_load) w_next = bus.param_data;
      end
      assign mac_w = w_q;
    end else begin : g_simple
      // param_load is deliberately not in any data path so X on it
      // cannot reach the outputs.
      logic unused_param_load;
      assign unused_param_load = bus.param_load;
      assign w_next = bus.param_data;
      assign mac_w  = bus.param_data;
    end
  endgenerate

  sys_array_mac #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
    .a   (bus.input_data),
    .b   (mac_w),
    .acc (bus.prop_data),
    .sum (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      w_q   <= '0;
      out_q <= '0;
    end else begin
      w_q   <= w_next;
      out_q <= mac_sum;
    end
  end

  assign bus.out_data   = out_q;
  assign bus.prop_param = w_q;
endmodule

// File: tb/tb_sys_array_pe.sv
module tb_sys_array_pe;
  import sys_array_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sys_array_pe_if #(.DATA_WIDTH(W)) lif ();
  sys_array_pe_if #(.DATA_WIDTH(W)) sif ();

  sys_array_pe #(.DATA_WIDTH(W), .TYPE(CELL_LOAD)) u_load (
    .clk(clk), .reset_n(reset_n), .bus(lif.slave)
  );
  sys_array_pe #(.DATA_WIDTH(W), .TYPE(CELL_SIMPLE)) u_simple (
    .clk(clk), .reset_n(reset_n), .bus(sif.slave)
  );

  // Same stimulus to both cells.
  task automatic drive(input logic ld, input logic signed [W-1:0] p,
                       input logic signed [W-1:0] x, input logic signed [2*W-1:0] acc);
    lif.param_load = ld;  sif.param_load = ld;
    lif.param_data = p;   sif.param_data = p;
    lif.input_data = x;   sif.input_data = x;
    lif.prop_data  = acc; sif.prop_data  = acc;
  endtask

  // Advance one edge; outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    drive(1'b1, 8'sd5, 8'sd3, 16'sd7);
    step(); step();
    checks++; if (lif.out_data !== 16'sd0) begin errors++; $display("FAIL reset_load_out got %0d want 0", lif.out_data); end
    checks++; if (lif.prop_param !== 8'sd0) begin errors++; $display("FAIL reset_load_pp got %0d want 0", lif.prop_param); end
    checks++; if (sif.out_data !== 16'sd0) begin errors++; $display("FAIL reset_simple_out got %0d want 0", sif.out_data); end
    checks++; if (sif.prop_param !== 8'sd0) begin errors++; $display("FAIL reset_simple_pp got %0d want 0", sif.prop_param); end
    reset_n = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 8'sd3, 8'sd4, 16'sd10);
    step();
    // load edge: LOAD still uses old weight 0
    checks++; if (lif.out_data !== 16'sd10) begin errors++; $display("FAIL basic_load_edge got %0d want 10", lif.out_data); end
    checks++; if (sif.out_data !== 16'sd22) begin errors++; $display("FAIL basic_simple_first got %0d want 22", sif.out_data); end
    lif.param_load = 1'b0; sif.param_load = 1'b0;
    step();
    checks++; if (lif.out_data !== 16'sd22) begin errors++; $display("FAIL basic_load_out got %0d want 22", lif.out_data); end
    checks++; if (sif.out_data !== 16'sd22) begin errors++; $display("FAIL basic_simple_out got %0d want 22", sif.out_data); end
    checks++; if (lif.prop_param !== 8'sd3) begin errors++; $display("FAIL basic_load_pp got %0d want 3", lif.prop_param); end
    checks++; if (sif.prop_param !== 8'sd3) begin errors++; $display("FAIL basic_simple_pp got %0d want 3", sif.prop_param); end
  endtask

  task automatic test_signed();
    drive(1'b1, -8'sd5, 8'sd7, -16'sd100);
    step();
    lif.param_load = 1'b0; sif.param_load = 1'b0;
    step();
    checks++; if (lif.out_data !== -16'sd135) begin errors++; $display("FAIL signed_load_out got %0d want -135", lif.out_data); end
    checks++; if (sif.out_data !== -16'sd135) begin errors++; $display("FAIL signed_simple_out got %0d want -135", sif.out_data); end
    checks++; if (lif.prop_param !== -8'sd5) begin errors++; $display("FAIL signed_load_pp got %0d want -5", lif.prop_param); end
  endtask

  task automatic test_extremes();
    drive(1'b1, -8'sd128, -8'sd128, 16'sd0);
    step();
    lif.param_load = 1'b0; sif.param_load = 1'b0;
    step();
    checks++; if (lif.out_data !== 16'sd16384) begin errors++; $display("FAIL ext_sq_load got %0d want 16384", lif.out_data); end
    checks++; if (sif.out_data !== 16'sd16384) begin errors++; $display("FAIL ext_sq_simple got %0d want 16384", sif.out_data); end
    // 32767 + 16384 = 49151 -> wraps to -16385
    lif.prop_data = 16'sd32767; sif.prop_data = 16'sd32767;
    step();
    checks++; if (lif.out_data !== -16'sd16385) begin errors++; $display("FAIL ext_wrap_load got %0d want -16385", lif.out_data); end
    checks++; if (sif.out_data !== -16'sd16385) begin errors++; $display("FAIL ext_wrap_simple got %0d want -16385", sif.out_data); end
    drive(1'b1, 8'sd127, -8'sd128, 16'sd32767);
    step();
    lif.param_load = 1'b0; sif.param_load = 1'b0;
    step();
    checks++; if (lif.out_data !== 16'sd16511) begin errors++; $display("FAIL ext_mix_load got %0d want 16511", lif.out_data); end
    checks++; if (sif.out_data !== 16'sd16511) begin errors++; $display("FAIL ext_mix_simple got %0d want 16511", sif.out_data); end
  endtask

  task automatic test_weight_hold();
    drive(1'b1, 8'sd2, 8'sd5, 16'sd1);
    step();
    drive(1'b0, 8'sd9, 8'sd5, 16'sd1);
    step();
    checks++; if (lif.out_data !== 16'sd11) begin errors++; $display("FAIL hold_load_out got %0d want 11", lif.out_data); end
    checks++; if (lif.prop_param !== 8'sd2) begin errors++; $display("FAIL hold_load_pp got %0d want 2", lif.prop_param); end
    checks++; if (sif.out_data !== 16'sd46) begin errors++; $display("FAIL hold_simple_out got %0d want 46", sif.out_data); end
    checks++; if (sif.prop_param !== 8'sd9) begin errors++; $display("FAIL hold_simple_pp got %0d want 9", sif.prop_param); end
  endtask

  // Relies on LOAD weight = 2 left by test_weight_hold.
  task automatic test_load_edge();
    drive(1'b1, 8'sd6, 8'sd3, 16'sd0);
    step();
    checks++; if (lif.out_data !== 16'sd6) begin errors++; $display("FAIL edge_old_w got %0d want 6", lif.out_data); end
    checks++; if (lif.prop_param !== 8'sd6) begin errors++; $display("FAIL edge_pp got %0d want 6", lif.prop_param); end
    checks++; if (sif.out_data !== 16'sd18) begin errors++; $display("FAIL edge_simple got %0d want 18", sif.out_data); end
    lif.param_load = 1'b0; sif.param_load = 1'b0;
    step();
    checks++; if (lif.out_data !== 16'sd18) begin errors++; $display("FAIL edge_new_w got %0d want 18", lif.out_data); end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b1;
    drive(1'b1, 8'sd7, 8'sd3, 16'sd50);
    step();
    checks++; if (lif.out_data !== 16'sd0) begin errors++; $display("FAIL mid_rst_out got %0d want 0", lif.out_data); end
    checks++; if (lif.prop_param !== 8'sd0) begin errors++; $display("FAIL mid_rst_pp got %0d want 0", lif.prop_param); end
    reset_n = 1'b0;
    drive(1'b0, 8'sd7, 8'sd3, 16'sd0);
    step();
    // weight was cleared, load was low: no residue of the pre-reset weight
    checks++; if (lif.out_data !== 16'sd0) begin errors++; $display("FAIL mid_rst_residue got %0d want 0", lif.out_data); end
    checks++; if (sif.out_data !== 16'sd21) begin errors++; $display("FAIL mid_rst_simple got %0d want 21", sif.out_data); end
  endtask

  task automatic test_simple_x();
    drive(1'b0, 8'sd4, 8'sd2, 16'sd1);
    sif.param_load = 1'bx;
    step();
    checks++; if (sif.out_data !== 16'sd9) begin errors++; $display("FAIL x_simple_out got %0d want 9", sif.out_data); end
    checks++; if (sif.prop_param !== 8'sd4) begin errors++; $display("FAIL x_simple_pp got %0d want 4", sif.prop_param); end
    sif.param_load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    drive(1'b0, '0, '0, '0);
    test_reset();
    test_basic();
    test_signed();
    test_extremes();
    test_weight_hold();
    test_load_edge();
    test_reset_mid();
    test_simple_x();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
